// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage, instruction FSM and decoder:
// default widths, reset PC and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_INST_W = 18;
    localparam int unsigned DEF_DISP_W = 8;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_RST   = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_READY = 2'd2;

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection: priority jump > branch > increment, plus the PC+1
// value used for the jump-and-link address.
module pc_next_logic
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DISP_W = DEF_DISP_W
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_sel_i,
    input  logic              br_take_i,
    input  logic              pc_inc_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic [DISP_W-1:0] br_disp_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output logic              cmd_o,
    output logic              jump_o
);

    logic [ADDR_W-1:0] disp_ext_s;
    logic [ADDR_W-1:0] pc_branch_s;

    // Adders wrap naturally modulo 2^ADDR_W.
    assign disp_ext_s  = {{(ADDR_W-DISP_W){br_disp_i[DISP_W-1]}}, br_disp_i};
    assign pc_plus1_o  = pc_i + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign pc_branch_s = pc_i + disp_ext_s;

    // Priority select of the command target.
    always_comb begin
        pc_next_o = pc_i;
        cmd_o     = 1'b0;
        jump_o    = 1'b0;
        if (jump_sel_i) begin
            pc_next_o = jump_target_i;
            cmd_o     = 1'b1;
            jump_o    = 1'b1;
        end else if (br_take_i) begin
            pc_next_o = pc_branch_s;
            cmd_o     = 1'b1;
        end else if (pc_inc_i) begin
            pc_next_o = pc_plus1_o;
            cmd_o     = 1'b1;
        end else begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and
// holds one instruction until the controller commands an advance.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned       DISP_W   = DEF_DISP_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              PC_inc,
    input  logic              JAddrSelect,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              br_take,
    input  logic [DISP_W-1:0] br_disp,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;

    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_plus1_s;
    logic              cmd_s;
    logic              jump_s;

    pc_next_logic #(
        .ADDR_W (ADDR_W),
        .DISP_W (DISP_W)
    ) u_pc_next (
        .pc_i          (pc_q),
        .jump_sel_i    (JAddrSelect),
        .br_take_i     (br_take),
        .pc_inc_i      (PC_inc),
        .jump_target_i (jump_target),
        .br_disp_i     (br_disp),
        .pc_next_o     (pc_next_s),
        .pc_plus1_o    (pc_plus1_s),
        .cmd_o         (cmd_s),
        .jump_o        (jump_s)
    );

    // Fetch FSM next-state and register updates.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        link_addr_d  = link_addr_q;
        case (state_q)
            ST_RST: begin
                state_d    = ST_FETCH;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
            end
            ST_FETCH: begin
                // Only an ack against a live request is accepted.
                if (mem_req_q && mem_ack) begin
                    inst_d       = mem_rdata;
                    inst_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = ST_READY;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_READY: begin
                if (cmd_s) begin
                    pc_d         = pc_next_s;
                    mem_addr_d   = pc_next_s;
                    mem_req_d    = 1'b1;
                    inst_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                    if (jump_s) begin
                        link_addr_d = pc_plus1_s;
                    end else begin
                        link_addr_d = link_addr_q;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d      = ST_RST;
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q      <= ST_RST;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= RESET_PC;
            inst_q       <= {INST_W{1'b0}};
            inst_valid_q <= 1'b0;
            link_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign link_addr  = link_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a memory responder and a
// cycle-level behavioural model checked on every falling edge.
module tb_instruction_fetch;

    logic        CLK;
    logic        CLR;
    logic        PC_inc;
    logic        JAddrSelect;
    logic [15:0] jump_target;
    logic        br_take;
    logic [7:0]  br_disp;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [17:0] mem_rdata;
    logic [17:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic [15:0] link_addr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int ack_delay = 0;
    bit withhold  = 1'b0;
    int wait_cnt  = 0;

    // Model: mode 0 = held in reset, 1 = fetching, 2 = holding instruction.
    int          m_mode = 0;
    logic [15:0] m_pc   = 16'h0000;
    logic [17:0] m_inst = 18'h00000;
    logic [15:0] m_link = 16'h0000;

    instruction_fetch dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .PC_inc      (PC_inc),
        .JAddrSelect (JAddrSelect),
        .jump_target (jump_target),
        .br_take     (br_take),
        .br_disp     (br_disp),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .link_addr   (link_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [17:0] memword(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'd7;
        return 18'h2A5A3 ^ {2'b00, m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of a held request.
    always @(negedge CLK) begin
        if (mem_req && !withhold && wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = memword(mem_addr);
            wait_cnt  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 18'h3FFFF;
            if (mem_req) wait_cnt = wait_cnt + 1;
            else         wait_cnt = 0;
        end
    end

    // Behavioural model of what the outputs must be after each edge.
    always @(posedge CLK) begin
        if (!CLR) begin
            m_mode <= 0;
            m_pc   <= 16'h0000;
            m_inst <= 18'h00000;
            m_link <= 16'h0000;
        end else if (m_mode == 0) begin
            m_mode <= 1;
        end else if (m_mode == 1) begin
            if (mem_ack) begin
                m_inst <= memword(m_pc);
                m_mode <= 2;
            end
        end else if (JAddrSelect) begin
            m_link <= 16'(int'(m_pc) + 1);
            m_pc   <= jump_target;
            m_mode <= 1;
        end else if (br_take) begin
            m_pc   <= 16'(int'(m_pc) + int'($signed(br_disp)));
            m_mode <= 1;
        end else if (PC_inc) begin
            m_pc   <= 16'(int'(m_pc) + 1);
            m_mode <= 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("mdl_mem_req", 32'(mem_req), 32'(m_mode == 1));
            check("mdl_mem_addr", 32'(mem_addr), 32'(m_pc));
            check("mdl_inst_valid", 32'(inst_valid), 32'(m_mode == 2));
            check("mdl_pc", 32'(pc), 32'(m_pc));
            check("mdl_link_addr", 32'(link_addr), 32'(m_link));
            if (m_mode != 1) check("mdl_inst", 32'(inst), 32'(m_inst));
        end
    end

    task automatic cmd(input logic j, input logic b, input logic i,
                       input logic [15:0] tgt, input logic [7:0] disp);
        JAddrSelect = j;
        br_take     = b;
        PC_inc      = i;
        jump_target = tgt;
        br_disp     = disp;
        @(negedge CLK);
        JAddrSelect = 1'b0;
        br_take     = 1'b0;
        PC_inc      = 1'b0;
    endtask

    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (inst_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!got) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        CLR = 1'b0;
        PC_inc = 1'b0;
        JAddrSelect = 1'b0;
        br_take = 1'b0;
        jump_target = 16'h0000;
        br_disp = 8'h00;
        mem_ack = 1'b0;
        mem_rdata = 18'h3FFFF;

        // Reset held for three cycles.
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0000);
        check("rst_inst", 32'(inst), 32'h00000);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_link", 32'(link_addr), 32'h0000);
        CLR = 1'b1;
        @(negedge CLK);
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", 32'(mem_addr), 32'h0000);
        @(negedge CLK);
        check("first_inst", 32'(inst), 32'h2A5A3);
        check("first_valid", 32'(inst_valid), 32'd1);
        check("first_pc", 32'(pc), 32'h0000);

        // Four wait states: request stable for five cycles.
        ack_delay = 4;
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
        for (int k = 0; k < 5; k++) begin
            check("ws_req", 32'(mem_req), 32'd1);
            check("ws_addr", 32'(mem_addr), 32'h0001);
            check("ws_valid", 32'(inst_valid), 32'd0);
            @(negedge CLK);
        end
        check("ws_valid_after", 32'(inst_valid), 32'd1);
        check("ws_inst", 32'(inst), 32'h2A5A4);
        ack_delay = 0;

        // Priority: all three commands, jump wins.
        cmd(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
        wait_ready();
        check("pri_pc_before", 32'(pc), 32'h0010);
        cmd(1'b1, 1'b1, 1'b1, 16'h1234, 8'h05);
        check("pri_addr", 32'(mem_addr), 32'h1234);
        check("pri_link", 32'(link_addr), 32'h0011);
        check("pri_valid_low", 32'(inst_valid), 32'd0);

        // Negative branch wraps below zero.
        wait_ready();
        cmd(1'b1, 1'b0, 1'b0, 16'h0002, 8'h00);
        wait_ready();
        cmd(1'b0, 1'b1, 1'b1, 16'h0000, 8'hFC);
        check("br_addr", 32'(mem_addr), 32'hFFFE);
        check("br_link_kept", 32'(link_addr), 32'h1235);

        // Increment wraps past 0xFFFF.
        wait_ready();
        cmd(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00);
        wait_ready();
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
        check("wrap_addr", 32'(mem_addr), 32'h0000);

        // Commands during FETCH are ignored.
        wait_ready();
        withhold = 1'b1;
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
        cmd(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
        check("ign_addr", 32'(mem_addr), 32'h0001);
        check("ign_pc", 32'(pc), 32'h0001);
        cmd(1'b1, 1'b1, 1'b0, 16'h7777, 8'h10);
        check("ign_jump_addr", 32'(mem_addr), 32'h0001);
        withhold = 1'b0;
        wait_ready();
        check("ign_pc_ready", 32'(pc), 32'h0001);
        repeat (2) @(negedge CLK);
        check("ign_no_refetch", 32'(mem_req), 32'd0);
        check("ign_still_valid", 32'(inst_valid), 32'd1);

        // Reset during a fetch at 0x0040.
        withhold = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, 16'h0040, 8'h00);
        check("mid_req", 32'(mem_req), 32'd1);
        check("mid_addr", 32'(mem_addr), 32'h0040);
        CLR = 1'b0;
        @(negedge CLK);
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'h0000);
        check("mid_rst_pc", 32'(pc), 32'h0000);
        check("mid_rst_link", 32'(link_addr), 32'h0000);
        check("mid_rst_inst", 32'(inst), 32'h00000);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        withhold = 1'b0;
        CLR = 1'b1;
        @(negedge CLK);
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h0000);
        wait_ready();
        check("restart_inst", 32'(inst), 32'h2A5A3);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the integrated controller/datapath. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It presents one 18-bit instruction with a valid flag and holds it until the controller's instruction FSM commands an advance (`PC_inc`), an absolute jump (`JAddrSelect`) or a relative branch. It also produces the link address the datapath writes on jump-and-link.

## Interface
- `ADDR_W`, 16, PC / memory address width
- `INST_W`, 18, instruction width
- `RESET_PC`, 16'h0000, PC value after reset
- `DISP_W`, 8, signed branch displacement width
- `CLK`  in  1  single clock, all state updates on rising edge
- `CLR`  in  1  reset, synchronous, active-low: state is reset on a rising `CLK` edge while `CLR`=0
- `PC_inc`  in  1  advance to PC+1 (from instruction FSM)
- `JAddrSelect`  in  1  load PC from `jump_target`
- `jump_target`  in  ADDR_W  absolute target (register A value)
- `br_take`  in  1  take relative branch
- `br_disp`  in  DISP_W  signed displacement, two's complement
- `mem_req`  out  1  read request to instruction memory
- `mem_addr`  out  ADDR_W  read address, valid while `mem_req`=1
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  INST_W  instruction word
- `inst`  out  INST_W  current instruction to decoder/FSM
- `inst_valid`  out  1  `inst` is valid and held
- `pc`  out  ADDR_W  address of `inst`
- `link_addr`  out  ADDR_W  PC+1 captured on the last jump

## Operation
- FSM states: RST, FETCH, READY.
- **RST**: entered while `CLR`=0. Leaves to FETCH on the first edge with `CLR`=1.
- **FETCH**: `mem_req`=1 and `mem_addr`=PC.
  - A request is held stable until `mem_ack` is sampled high.
  - `mem_ack` is honoured in any cycle with `mem_req`=1, including the first.
  - On ack: `inst`<=`mem_rdata`, then go to READY.
- **READY**: `inst_valid`=1, `mem_req`=0, `inst` and `pc` held. Commands are evaluated each cycle with priority `JAddrSelect` > `br_take` > `PC_inc`:
  - jump: PC<=`jump_target`, `link_addr`<=PC+1.
  - branch: PC<=PC+sign_extend(`br_disp`).
  - inc: PC<=PC+1.
  - Any command: go to FETCH, `inst_valid`<=0.
  - No command: stay in READY.
- Commands are ignored outside READY. `mem_ack` is ignored outside FETCH.
- Arithmetic is modulo 2^ADDR_W. Examples: 16'hFFFF+1 wraps to 16'h0000; 16'h0002 with disp 8'hFC gives 16'hFFFE.
- Reset values: PC=RESET_PC, `mem_req`=0, `mem_addr`=RESET_PC, `inst`=0, `inst_valid`=0, `pc`=RESET_PC, `link_addr`=0.
- Reset mid-fetch: the outstanding request is dropped (`mem_req`=0 on the next edge). A late `mem_ack` after reset release is only used if the new request is already up. Memory therefore must not ack a request that was dropped.

## Timing
- `mem_req` rises on the first edge after `CLR` returns high.
- Ack in cycle N: `inst`/`inst_valid` are updated at edge N. The controller sees the instruction in cycle N+1.
- A command in READY cycle M: `mem_req`=1 with the new `mem_addr` in cycle M+1, and `inst_valid`=0 in cycle M+1.
- Zero-wait memory (ack in the same cycle as req): an instruction every 2 cycles.
- `inst_valid` never stays high across a PC change. `pc` always equals the address `inst` was fetched from.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (RST/FETCH/READY), `RESET_PC`, and `ADDR_W`/`INST_W`/`DISP_W` defaults, shared with the instruction FSM and decoder.
- One natural sub-module: `pc_next_logic`. It is combinational: priority select and the adders PC+1, PC+disp and the jump target. The FSM and registers stay in the top module.

## Test plan
- Reset, zero-wait memory: hold `CLR`=0 for 3 cycles, then release → `mem_req`=1, `mem_addr`=0x0000 on the first edge; returned word 18'h2A5A3 appears with `inst_valid`=1 and `pc`=0x0000 one cycle later.
- Wait states: ack delayed 4 cycles → `mem_req` and `mem_addr` stable for all 5 cycles; `inst_valid` stays low until the edge after ack.
- Priority: in READY with PC=0x0010, assert `JAddrSelect`, `br_take` and `PC_inc` together, `jump_target`=0x1234 → next `mem_addr`=0x1234, `link_addr`=0x0011.
- Branch and wrap:
  - PC=0x0002, `br_disp`=8'hFC → `mem_addr`=0xFFFE.
  - PC=0xFFFF with `PC_inc` → `mem_addr`=0x0000.
- Commands outside READY: pulse `PC_inc` during FETCH while ack is withheld → PC unchanged and no extra fetch.
- Reset mid-operation: assert `CLR`=0 during FETCH at 0x0040 → next edge shows all outputs at reset values; after release the fetch restarts at `RESET_PC`.
